// File: rtl/reg_sb_pkg.sv
// Shared constants, field positions and the write-back slot record for the
// register scoreboard and its write-back slot queue.
package reg_sb_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int LAT_W = 3;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } slot_t;

    function automatic logic [REG_W-1:0] f_rs(input logic [31:0] inst);
        return inst[RS_HI:RS_LO];
    endfunction

    function automatic logic [REG_W-1:0] f_rt(input logic [31:0] inst);
        return inst[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/wb_slot_queue.sv
// Write-back schedule: slot k holds the write performed k-1 cycles from now.
// Entries shift toward slot 1 each cycle; a new entry lands at slot L after the shift.
module wb_slot_queue
    import reg_sb_pkg::*;
#(
    parameter int MAX_LAT = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_ins_valid,
    input  logic [REG_W-1:0]            i_ins_rd,
    input  logic [LAT_W-1:0]            i_ins_lat,
    output logic [MAX_LAT:1]            o_slot_valid,
    output logic [MAX_LAT:1][REG_W-1:0] o_slot_rd,
    output logic [NREG-1:0]             o_busy
);

    slot_t r_slot  [1:MAX_LAT];
    slot_t w_shift [1:MAX_LAT];
    slot_t w_next  [1:MAX_LAT];

    // Shift by one slot, then place the accepted write at its latency slot
    always_comb begin
        for (int k = 1; k < MAX_LAT; k++) begin
            w_shift[k] = r_slot[k+1];
        end
        w_shift[MAX_LAT] = '0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            w_next[k] = (i_ins_valid && (i_ins_lat == LAT_W'(k))) ?
                        '{valid: 1'b1, rd: i_ins_rd} : w_shift[k];
        end
    end

    // Slot storage with asynchronous clear and flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= MAX_LAT; k++) r_slot[k] <= '0;
        end else if (i_flush) begin
            for (int k = 1; k <= MAX_LAT; k++) r_slot[k] <= '0;
        end else begin
            for (int k = 1; k <= MAX_LAT; k++) r_slot[k] <= w_next[k];
        end
    end

    // Slot 1 is written this cycle and bypassed, so it does not count as busy
    always_comb begin
        o_busy = '0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            o_slot_valid[k] = r_slot[k].valid;
            o_slot_rd[k]    = r_slot[k].rd;
        end
        for (int k = 2; k <= MAX_LAT; k++) begin
            o_busy[r_slot[k].rd] = o_busy[r_slot[k].rd] | r_slot[k].valid;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW, WAW and write-port hazard detection in front of a
// fixed-latency write-back schedule, plus a saturating stall counter.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int MAX_LAT = 7,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [31:0]      issue_inst,
    input  logic             use_rt,
    input  logic             issue_wr,
    input  logic [4:0]       issue_dst,
    input  logic [2:0]       issue_lat,
    input  logic             flush,
    output logic             issue_accept,
    output logic             stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [REG_W-1:0]            w_rs;
    logic [REG_W-1:0]            w_rt;
    logic [LAT_W-1:0]            w_eff_lat;
    logic [MAX_LAT:1]            w_slot_valid;
    logic [MAX_LAT:1][REG_W-1:0] w_slot_rd;
    logic [NREG-1:0]             w_busy;
    logic                        w_raw;
    logic                        w_waw;
    logic                        w_port;
    logic                        w_dst_live;
    logic                        w_ins;
    logic                        w_unused_bits;
    logic [CNT_W-1:0]            r_stall_cnt;

    assign w_rs          = f_rs(issue_inst);
    assign w_rt          = f_rt(issue_inst);
    assign w_unused_bits = ^{issue_inst[31:26], issue_inst[15:0]};

    // Latency 0 behaves as 1; anything beyond the queue depth is clamped
    always_comb begin
        if (issue_lat == 3'd0) begin
            w_eff_lat = 3'd1;
        end else if (int'(issue_lat) > MAX_LAT) begin
            w_eff_lat = LAT_W'(MAX_LAT);
        end else begin
            w_eff_lat = issue_lat;
        end
    end

    // Slot L+1 writes in cycle t+L; slots beyond it write later than the new instruction
    always_comb begin
        w_waw  = 1'b0;
        w_port = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            w_port = w_port | (w_slot_valid[k] && (k == int'(w_eff_lat) + 1));
            w_waw  = w_waw  | (w_slot_valid[k] && (k > int'(w_eff_lat)) &&
                               (w_slot_rd[k] == issue_dst));
        end
    end

    assign w_raw = ((w_rs != 5'd0) && w_busy[w_rs]) ||
                   (use_rt && (w_rt != 5'd0) && w_busy[w_rt]);
    assign w_dst_live   = issue_wr && (issue_dst != 5'd0);
    assign stall        = issue_valid && (w_raw || (w_dst_live && (w_waw || w_port)));
    assign issue_accept = rst && issue_valid && !stall && !flush;
    assign w_ins        = issue_accept && w_dst_live;
    assign rf_we        = w_slot_valid[1] && !flush;
    assign rf_waddr     = w_slot_rd[1];
    assign stall_cnt    = r_stall_cnt;

    wb_slot_queue #(.MAX_LAT(MAX_LAT)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_ins_valid  (w_ins),
        .i_ins_rd     (issue_dst),
        .i_ins_lat    (w_eff_lat),
        .o_slot_valid (w_slot_valid),
        .o_slot_rd    (w_slot_rd),
        .o_busy       (w_busy)
    );

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a pending-write list model checked
// every cycle, plus directed sequences with hand-computed expectations.
module tb_reg_scoreboard;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic [31:0]   issue_inst = 32'd0;
    logic          use_rt = 1'b0;
    logic          issue_wr = 1'b0;
    logic [4:0]    issue_dst = 5'd0;
    logic [2:0]    issue_lat = 3'd0;
    logic          flush = 1'b0;
    logic          issue_accept;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [CW-1:0] stall_cnt;

    reg_scoreboard #(.MAX_LAT(7), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_inst   (issue_inst),
        .use_rt       (use_rt),
        .issue_wr     (issue_wr),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .issue_accept (issue_accept),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int due;
        int rd;
    } wr_t;

    wr_t pend[$];
    int  cyc   = 0;
    int  cnt_m = 0;

    int s_we, s_waddr, s_stall, s_acc, s_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit busy_at(input int r, input int now);
        foreach (pend[i]) if (pend[i].rd == r && pend[i].due > now) return 1'b1;
        return 1'b0;
    endfunction

    // Model: list of pending writes with absolute due cycles
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_we", int'(rf_we), 0);
            chk("rst_waddr", int'(rf_waddr), 0);
            chk("rst_accept", int'(issue_accept), 0);
            chk("rst_cnt", int'(stall_cnt), 0);
            pend.delete();
            cnt_m = 0;
        end else begin
            int rs, rt, dst, lat;
            bit raw, waw, port, est, eacc, ewe;
            int ewa;
            rs  = int'(issue_inst[25:21]);
            rt  = int'(issue_inst[20:16]);
            dst = int'(issue_dst);
            lat = (issue_lat == 3'd0) ? 1 : int'(issue_lat);
            raw = (rs != 0 && busy_at(rs, cyc)) || (use_rt && rt != 0 && busy_at(rt, cyc));
            waw = 1'b0; port = 1'b0; ewe = 1'b0; ewa = 0;
            foreach (pend[i]) begin
                if (pend[i].rd == dst && pend[i].due >= cyc + lat) waw = 1'b1;
                if (pend[i].due == cyc + lat) port = 1'b1;
                if (pend[i].due == cyc) begin ewe = !flush; ewa = pend[i].rd; end
            end
            est  = issue_valid && (raw || (issue_wr && dst != 0 && (waw || port)));
            eacc = issue_valid && !est && !flush;
            chk("stall", int'(stall), int'(est));
            chk("accept", int'(issue_accept), int'(eacc));
            chk("rf_we", int'(rf_we), int'(ewe));
            if (ewe) chk("rf_waddr", int'(rf_waddr), ewa);
            chk("stall_cnt", int'(stall_cnt), cnt_m);
            if (flush) begin
                pend.delete();
            end else begin
                for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
            end
            if (eacc && issue_wr && dst != 0) pend.push_back('{due: cyc + lat, rd: dst});
            if (est && cnt_m < (1 << CW) - 1) cnt_m++;
            cyc++;
        end
    end

    task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                         input bit wr, input int dst, input int lat, input bit fl);
        logic [4:0] rs5, rt5;
        rs5 = 5'(rs);
        rt5 = 5'(rt);
        issue_valid = v;
        issue_inst  = {6'd0, rs5, rt5, 16'd0};
        use_rt      = urt;
        issue_wr    = wr;
        issue_dst   = 5'(dst);
        issue_lat   = 3'(lat);
        flush       = fl;
        @(negedge clk); #1;
        s_we = int'(rf_we); s_waddr = int'(rf_waddr); s_stall = int'(stall);
        s_acc = int'(issue_accept); s_cnt = int'(stall_cnt);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we_lit", int'(rf_we), 0);
        rst = 1'b1;

        // RAW on r5 scheduled with L=3: stalls two cycles, then bypass allows accept
        drive(1, 0, 0, 0, 1, 5, 3, 0); chk("t36_acc0", s_acc, 1);
        drive(1, 5, 0, 0, 0, 0, 1, 0); chk("t36_stall1", s_stall, 1);
        drive(1, 5, 0, 0, 0, 0, 1, 0); chk("t36_stall2", s_stall, 1);
        drive(1, 5, 0, 0, 0, 0, 1, 0); chk("t36_acc3", s_acc, 1);
        chk("t36_we3", s_we, 1); chk("t36_cnt", s_cnt, 2);
        idle(); chk("t36_we4", s_we, 0);

        // Single write r5, L=3: pulse in cycle 3 only
        drive(1, 0, 0, 0, 1, 5, 3, 0); chk("t35_acc", s_acc, 1); chk("t35_we0", s_we, 0);
        idle(); chk("t35_we1", s_we, 0);
        idle(); chk("t35_we2", s_we, 0);
        idle(); chk("t35_we3", s_we, 1); chk("t35_wa3", s_waddr, 5);
        idle(); chk("t35_we4", s_we, 0);

        // Write-port conflict
        drive(1, 0, 0, 0, 1, 7, 2, 0); chk("t37_acc0", s_acc, 1);
        drive(1, 0, 0, 0, 1, 8, 1, 0); chk("t37_stall1", s_stall, 1);
        drive(1, 0, 0, 0, 1, 8, 1, 0); chk("t37_acc2", s_acc, 1);
        chk("t37_we2", s_we, 1); chk("t37_wa2", s_waddr, 7);
        idle(); chk("t37_we3", s_we, 1); chk("t37_wa3", s_waddr, 8);
        idle(); chk("t37_cnt", s_cnt, 3);

        // Register 0 everywhere: no stall, no write
        drive(1, 0, 0, 1, 1, 0, 1, 0); chk("t38_stall", s_stall, 0); chk("t38_acc", s_acc, 1);
        for (int i = 0; i < 3; i++) begin idle(); chk("t38_we", s_we, 0); end

        // Latency 0 behaves as 1
        drive(1, 0, 0, 0, 1, 9, 0, 0); chk("lat0_acc", s_acc, 1);
        idle(); chk("lat0_we", s_we, 1); chk("lat0_wa", s_waddr, 9);

        // WAW: r3 due at cycle 5 blocks a later r3 write until it would land after it
        drive(1, 0, 0, 0, 1, 3, 5, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, 3, 2, 0); chk("waw_stall", s_stall, 1);
        end
        drive(1, 0, 0, 0, 1, 3, 2, 0); chk("waw_acc", s_acc, 1);
        idle(); chk("waw_we5", s_we, 1); chk("waw_wa5", s_waddr, 3);
        idle(); chk("waw_we6", s_we, 1); chk("waw_wa6", s_waddr, 3);

        // Flush suppresses a write due in the flush cycle
        drive(1, 0, 0, 0, 1, 4, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1); chk("fl_we", s_we, 0);
        idle(); chk("fl_we_after", s_we, 0);

        // Three pending writes flushed; reader of them accepted at once
        drive(1, 0, 0, 0, 1, 10, 5, 0);
        drive(1, 0, 0, 0, 1, 11, 6, 0);
        drive(1, 0, 0, 0, 1, 12, 7, 0);
        drive(1, 0, 0, 0, 1, 13, 1, 1); chk("t39_flush_acc", s_acc, 0);
        drive(1, 10, 11, 1, 1, 12, 1, 0); chk("t39_acc", s_acc, 1); chk("t39_stall", s_stall, 0);
        idle(); chk("t39_we_new", s_we, 1); chk("t39_wa_new", s_waddr, 12);
        for (int i = 0; i < 7; i++) begin idle(); chk("t39_we_none", s_we, 0); end

        // Asynchronous reset with writes in flight
        drive(1, 0, 0, 0, 1, 13, 4, 0);
        drive(1, 0, 0, 0, 1, 14, 6, 0);
        idle(); idle();
        chk("t40_we_before", int'(rf_we), 1);
        issue_valid = 1'b1; issue_inst = 32'd0; issue_wr = 1'b1; issue_dst = 5'd20; issue_lat = 3'd2;
        #2 rst = 1'b0;
        #1;
        chk("t40_async_we", int'(rf_we), 0);
        chk("t40_async_wa", int'(rf_waddr), 0);
        chk("t40_async_acc", int'(issue_accept), 0);
        chk("t40_async_cnt", int'(stall_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin idle(); chk("t40_we_none", s_we, 0); end

        // Self-dependent r15 chain keeps stalling until the counter saturates
        for (int i = 0; i < 320; i++) drive(1, 15, 0, 0, 1, 15, 7, 0);
        chk("t40_sat", s_cnt, 255);
        idle(); chk("t40_sat_hold", s_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter MAX_LAT, default 7: largest write-back latency, in cycles, that can be scheduled.
REQ-002 Parameter CNT_W, default 16: width of the stall statistics counter.
REQ-003 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-004 Port rst  in  1: reset, asynchronous, active-low.
REQ-005 Port issue_valid  in  1: decode stage presents an instruction this cycle.
REQ-006 Port issue_inst  in  32: instruction word; rs = bits 25:21, rt = bits 20:16.
REQ-007 Port use_rt  in  1: instruction reads rt (rs is always read).
REQ-008 Port issue_wr  in  1: instruction writes a destination register.
REQ-009 Port issue_dst  in  5: destination register index.
REQ-010 Port issue_lat  in  3: cycles from acceptance to register-file write, 1..MAX_LAT; 0 is treated as 1.
REQ-011 Port flush  in  1: discard all pending scheduled writes.
REQ-012 Port issue_accept  out  1: issue_valid and not stall and not flush.
REQ-013 Port stall  out  1: decode must hold its instruction this cycle.
REQ-014 Port rf_we  out  1: register-file write enable (drives RegWrite).
REQ-015 Port rf_waddr  out  5: register-file write index.
REQ-016 Port stall_cnt  out  CNT_W: saturating count of stalled cycles.

Function
REQ-017 Each accepted instruction with issue_wr=1 and issue_dst!=0 SHALL assert rf_we with rf_waddr=issue_dst in exactly cycle t+L, where t is the accept cycle and L is the effective latency.
REQ-018 Writes to register 0 SHALL never be scheduled and SHALL never cause a stall.
REQ-019 A register SHALL be busy while it has any scheduled write not yet performed.
REQ-020 In the cycle its write is performed (rf_we=1 and rf_waddr=r), register r SHALL NOT be busy for source checks, because the register file bypasses same-cycle writes.
REQ-021 RAW hazard: stall SHALL be 1 if issue_valid, and rs!=0 is busy or (use_rt and rt!=0 is busy).
REQ-022 WAW hazard: stall SHALL be 1 if issue_valid, issue_wr, issue_dst!=0, and issue_dst is busy with a write scheduled at or after cycle t+L.
REQ-023 Port conflict: stall SHALL be 1 if issue_valid, issue_wr, issue_dst!=0, and a write is already scheduled for cycle t+L (one write port).
REQ-024 stall SHALL be 0 whenever issue_valid is 0; stall is combinational from the inputs and the current schedule.
REQ-025 A stalled instruction SHALL NOT alter the schedule; the same instruction is re-evaluated every cycle until accepted.
REQ-026 Schedule: a MAX_LAT-entry slot queue of {valid, reg} indexed by cycles remaining, shifting one slot per cycle; slot 1 drives rf_we and rf_waddr.
REQ-027 Flush: on the flush edge all slots SHALL clear; issue_accept=0 during flush; rf_we SHALL be 0 in the flush cycle.
REQ-028 stall_cnt SHALL increment by 1 on each cycle with stall=1 and SHALL saturate at all-ones.
REQ-029 Accept and the shift in the same cycle SHALL compose: existing entries shift first, then the new entry is placed at slot L.

Reset
REQ-030 While rst=0: all slots invalid, rf_we=0, rf_waddr=0, stall_cnt=0, issue_accept=0; asynchronous assertion.
REQ-031 Reset mid-operation SHALL drop every pending write with no rf_we pulse afterwards.
REQ-032 The first accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-033 Package reg_sb_pkg SHALL hold NREG=32, REG_W=5, LAT_W=3, the RS_HI/RS_LO/RT_HI/RT_LO field positions, and the slot record type {valid, reg}.
REQ-034 One sub-module, wb_slot_queue, SHALL hold the shift queue, the insert-at-L logic and the per-register busy vector; reg_scoreboard holds the hazard logic and the counter.

Verification
REQ-035 Reset, then accept writes r5 with L=3 at cycle 0 -> rf_we=1, rf_waddr=5 at cycle 3 only.
REQ-036 Write r5 with L=3 at cycle 0, then an instruction reading rs=5 -> stall=1 in cycles 1 and 2, accept in cycle 3, stall_cnt=2.
REQ-037 Write r7 with L=2 at cycle 0, then write r8 with L=1 at cycle 1 -> stall=1 at cycle 1 (port conflict), accepted at cycle 2, writes at cycles 2 and 3.
REQ-038 Instruction with rs=0, rt=0, dst=0, L=1 -> never stalls, rf_we never asserted.
REQ-039 Schedule three writes, assert flush at cycle 1 -> no rf_we thereafter; next instruction reading those registers accepted immediately.
REQ-040 Drive rst low while writes are pending -> outputs are zero immediately; hold stall for 2^CNT_W+5 cycles -> stall_cnt stays at all-ones.
